// File: rtl/status_flags_reg.sv
// status_flags_reg: architectural CPSR flags {C,N,V,Z} with one saved SPSR copy
// for exception entry/return, plus a same-cycle bypass for the condition check.
module status_flags_reg #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000,
   parameter bit         FWD_EN      = 1'b1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] Alu_flags,
   input  logic       S_en,
   input  logic [3:0] Wr_mask,
   input  logic       Save,
   input  logic       Restore,
   output logic [3:0] Flags_q,
   output logic [3:0] Flags_fwd,
   output logic [3:0] Spsr_q,
   output logic       Saved,
   output logic       Err
);

   typedef enum logic {
      IDLE  = 1'b0,
      SAVED = 1'b1
   } state_t;

   state_t     state_r;
   state_t     state_next_s;
   logic [3:0] flags_r;
   logic [3:0] spsr_r;
   logic       saved_r;
   logic       err_r;
   logic [3:0] cpsr_next_s;
   logic [3:0] spsr_next_s;
   logic       err_next_s;
   logic       legal_restore_s;

   // Next CPSR/SPSR/state; a legal Restore wins over S_en, an illegal one only flags Err.
   always_comb begin
      legal_restore_s = Restore && (state_r == SAVED);
      cpsr_next_s     = flags_r;
      spsr_next_s     = spsr_r;
      err_next_s      = 1'b0;
      state_next_s    = state_r;

      if (legal_restore_s) begin
         cpsr_next_s = spsr_r;
         err_next_s  = S_en;
      end else if (S_en) begin
         cpsr_next_s = (Alu_flags & Wr_mask) | (flags_r & ~Wr_mask);
         err_next_s  = Restore;
      end else begin
         cpsr_next_s = flags_r;
         err_next_s  = Restore;
      end

      // Save always captures the pre-edge CPSR, even when swapping with Restore.
      if (Save) begin
         spsr_next_s = flags_r;
      end else begin
         spsr_next_s = spsr_r;
      end

      case (state_r)
         IDLE: begin
            if (Save) begin
               state_next_s = SAVED;
            end else begin
               state_next_s = IDLE;
            end
         end
         SAVED: begin
            if (Restore && !Save) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = SAVED;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Flag, SPSR and state registers with asynchronous reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         flags_r <= RESET_FLAGS;
         spsr_r  <= RESET_FLAGS;
         state_r <= IDLE;
         saved_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         flags_r <= cpsr_next_s;
         spsr_r  <= spsr_next_s;
         state_r <= state_next_s;
         saved_r <= (state_next_s == SAVED);
         err_r   <= err_next_s;
      end
   end

   assign Flags_q   = flags_r;
   assign Spsr_q    = spsr_r;
   assign Saved     = saved_r;
   assign Err       = err_r;
   assign Flags_fwd = FWD_EN ? cpsr_next_s : flags_r;

endmodule

// File: tb/tb_status_flags_reg.sv
// tb_status_flags_reg: directed scenarios plus randomized traffic checked against
// a rule-level reference model of the CPSR/SPSR flag register.
module tb_status_flags_reg;

   logic       clk;
   logic       rst;
   logic [3:0] alu;
   logic       s_en;
   logic [3:0] wr_mask;
   logic       save;
   logic       restore;
   logic [3:0] flags_q;
   logic [3:0] flags_fwd;
   logic [3:0] spsr_q;
   logic       saved;
   logic       err;

   int n_vec;
   int n_miss;

   // reference model state
   logic [3:0] m_cpsr;
   logic [3:0] m_spsr;
   logic       m_saved;
   logic       m_err;
   logic [3:0] exp_fwd;
   logic [3:0] obs_fwd;
   logic [3:0] pre_q;

   status_flags_reg #(
      .RESET_FLAGS(4'b0000),
      .FWD_EN     (1'b1)
   ) dut (
      .Clk      (clk),
      .Reset    (rst),
      .Alu_flags(alu),
      .S_en     (s_en),
      .Wr_mask  (wr_mask),
      .Save     (save),
      .Restore  (restore),
      .Flags_q  (flags_q),
      .Flags_fwd(flags_fwd),
      .Spsr_q   (spsr_q),
      .Saved    (saved),
      .Err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_cpsr  = 4'b0000;
      m_spsr  = 4'b0000;
      m_saved = 1'b0;
      m_err   = 1'b0;
   endtask

   // Drive one instruction's inputs at negedge, capture the bypass, clock it in,
   // and advance the model; outputs are then stable at posedge+1.
   task automatic step(input logic [3:0] a, input logic s, input logic [3:0] m,
                       input logic sv, input logic rs);
      logic [3:0] n_cpsr;
      logic [3:0] n_spsr;
      logic       n_saved;
      logic       n_err;
      logic       legal;
      @(negedge clk);
      alu = a; s_en = s; wr_mask = m; save = sv; restore = rs;
      pre_q = flags_q;
      legal = rs && m_saved;
      n_cpsr = m_cpsr;
      if (legal) n_cpsr = m_spsr;
      else if (s) begin
         for (int i = 0; i < 4; i++) if (m[i]) n_cpsr[i] = a[i];
      end
      n_spsr  = sv ? m_cpsr : m_spsr;
      n_saved = sv ? 1'b1 : (legal ? 1'b0 : m_saved);
      n_err   = (rs && !m_saved) || (legal && s);
      exp_fwd = n_cpsr;
      #1;
      obs_fwd = flags_fwd;
      @(posedge clk);
      #1;
      m_cpsr = n_cpsr; m_spsr = n_spsr; m_saved = n_saved; m_err = n_err;
      alu = 4'b0000; s_en = 1'b0; wr_mask = 4'b0000; save = 1'b0; restore = 1'b0;
   endtask

   task automatic test_reset();
      n_vec++;
      if (flags_q !== 4'b0000 || spsr_q !== 4'b0000 || saved !== 1'b0 || err !== 1'b0) begin
         n_miss++;
         $display("FAIL reset_state: got q=%b spsr=%b saved=%b err=%b, want 0000 0000 0 0",
                  flags_q, spsr_q, saved, err);
      end
      step(4'b1111, 1'b1, 4'b1111, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
      n_vec++;
      if (flags_q !== 4'b1111 || spsr_q !== 4'b1111 || saved !== 1'b1) begin
         n_miss++;
         $display("FAIL pre_reset_setup: got q=%b spsr=%b saved=%b, want 1111 1111 1",
                  flags_q, spsr_q, saved);
      end
      #3;
      rst = 1'b1;
      #1;
      n_vec++;
      if (flags_q !== 4'b0000 || spsr_q !== 4'b0000 || saved !== 1'b0 || err !== 1'b0) begin
         n_miss++;
         $display("FAIL async_reset: got q=%b spsr=%b saved=%b err=%b, want 0000 0000 0 0",
                  flags_q, spsr_q, saved, err);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_update();
      step(4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0);
      n_vec++;
      if (obs_fwd !== 4'b0001) begin
         n_miss++;
         $display("FAIL fwd_same_cycle: got %b, want 0001", obs_fwd);
      end
      n_vec++;
      if (flags_q !== 4'b0001 || err !== 1'b0) begin
         n_miss++;
         $display("FAIL full_update: got q=%b err=%b, want 0001 0", flags_q, err);
      end
      step(4'b1010, 1'b1, 4'b1111, 1'b0, 1'b0);
      step(4'b0101, 1'b1, 4'b1101, 1'b0, 1'b0);
      n_vec++;
      if (flags_q !== 4'b0111) begin
         n_miss++;
         $display("FAIL mask_keep_v: got %b, want 0111", flags_q);
      end
      step(4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0);
      n_vec++;
      if (flags_q !== 4'b0111 || err !== 1'b0 || obs_fwd !== 4'b0111) begin
         n_miss++;
         $display("FAIL zero_mask: got q=%b fwd=%b err=%b, want 0111 0111 0", flags_q, obs_fwd, err);
      end
   endtask

   task automatic test_save_restore();
      step(4'b1000, 1'b1, 4'b1111, 1'b0, 1'b0);
      step(4'b0100, 1'b1, 4'b1111, 1'b1, 1'b0);
      n_vec++;
      if (spsr_q !== 4'b1000 || flags_q !== 4'b0100 || saved !== 1'b1 || obs_fwd !== 4'b0100) begin
         n_miss++;
         $display("FAIL save_with_update: got spsr=%b q=%b saved=%b fwd=%b, want 1000 0100 1 0100",
                  spsr_q, flags_q, saved, obs_fwd);
      end
      step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
      n_vec++;
      if (flags_q !== 4'b1000 || saved !== 1'b0 || err !== 1'b0) begin
         n_miss++;
         $display("FAIL restore: got q=%b saved=%b err=%b, want 1000 0 0", flags_q, saved, err);
      end
      step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
      n_vec++;
      if (obs_fwd !== 4'b1000 || spsr_q !== 4'b1000 || saved !== 1'b1) begin
         n_miss++;
         $display("FAIL save_alone: got fwd=%b spsr=%b saved=%b, want 1000 1000 1", obs_fwd, spsr_q, saved);
      end
      step(4'b0110, 1'b1, 4'b1111, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
      n_vec++;
      if (flags_q !== 4'b1000 || saved !== 1'b0 || err !== 1'b0) begin
         n_miss++;
         $display("FAIL nested_save: got q=%b saved=%b err=%b, want 1000 0 0", flags_q, saved, err);
      end
   endtask

   task automatic test_err();
      step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
      n_vec++;
      if (flags_q !== 4'b1000 || err !== 1'b1 || saved !== 1'b0) begin
         n_miss++;
         $display("FAIL idle_restore: got q=%b err=%b saved=%b, want 1000 1 0", flags_q, err, saved);
      end
      step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      n_vec++;
      if (err !== 1'b0) begin
         n_miss++;
         $display("FAIL err_one_cycle: got %b, want 0", err);
      end
      step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
      step(4'b0011, 1'b1, 4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b1, 4'b1111, 1'b0, 1'b1);
      n_vec++;
      if (flags_q !== 4'b1000 || err !== 1'b1 || saved !== 1'b0 || obs_fwd !== 4'b1000) begin
         n_miss++;
         $display("FAIL restore_drops_update: got q=%b err=%b saved=%b fwd=%b, want 1000 1 0 1000",
                  flags_q, err, saved, obs_fwd);
      end
   endtask

   task automatic test_swap();
      step(4'b1100, 1'b1, 4'b1111, 1'b1, 1'b0);
      step(4'b1100, 1'b1, 4'b1111, 1'b1, 1'b0);
      step(4'b0011, 1'b1, 4'b1111, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
      n_vec++;
      if (flags_q !== 4'b1100 || spsr_q !== 4'b0011 || saved !== 1'b1 || err !== 1'b0) begin
         n_miss++;
         $display("FAIL swap_saved: got q=%b spsr=%b saved=%b err=%b, want 1100 0011 1 0",
                  flags_q, spsr_q, saved, err);
      end
      step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
      n_vec++;
      if (flags_q !== 4'b0011 || spsr_q !== 4'b0011 || saved !== 1'b1 || err !== 1'b1) begin
         n_miss++;
         $display("FAIL swap_idle: got q=%b spsr=%b saved=%b err=%b, want 0011 0011 1 1",
                  flags_q, spsr_q, saved, err);
      end
   endtask

   task automatic test_random(input int iters);
      logic [3:0] a;
      logic [3:0] m;
      logic       s;
      logic       sv;
      logic       rs;
      for (int k = 0; k < iters; k++) begin
         a  = 4'($urandom_range(15, 0));
         m  = ($urandom_range(3, 0) == 0) ? 4'b1101 : 4'($urandom_range(15, 0));
         s  = 1'($urandom_range(1, 0));
         sv = ($urandom_range(5, 0) == 0);
         rs = ($urandom_range(5, 0) == 0);
         step(a, s, m, sv, rs);
         n_vec++;
         if (obs_fwd !== exp_fwd || flags_q !== m_cpsr || spsr_q !== m_spsr ||
             saved !== m_saved || err !== m_err) begin
            n_miss++;
            $display("FAIL random[%0d]: got fwd=%b q=%b spsr=%b saved=%b err=%b, want %b %b %b %b %b",
                     k, obs_fwd, flags_q, spsr_q, saved, err,
                     exp_fwd, m_cpsr, m_spsr, m_saved, m_err);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 16; k++) begin
         step(4'($urandom_range(15, 0)), 1'b1, 4'(k), 1'b0, 1'b0);
         n_vec++;
         if (flags_q !== m_cpsr || obs_fwd !== m_cpsr || err !== 1'b0) begin
            n_miss++;
            $display("FAIL back_to_back[%0d]: got q=%b fwd=%b err=%b, want %b %b 0",
                     k, flags_q, obs_fwd, err, m_cpsr, m_cpsr);
         end
      end
   endtask

   initial begin
      n_vec = 0; n_miss = 0;
      alu = 4'b0000; s_en = 1'b0; wr_mask = 4'b0000; save = 1'b0; restore = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_update();
      test_save_restore();
      test_err();
      test_swap();
      test_back_to_back();
      test_random(400);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
